task_dispatcher: RTL and testbench
==================================

Name: task_dispatcher

Overview:
- Upstream stage of the MHP task manager. Queues 16-bit task numbers from local requesters (keypad/UI logic) in a small FIFO.
- Presents one task at a time to the manager as a single-cycle start pulse plus task number, then waits for the manager's address-grant strobe.
- On grant, captures the returned dest/src addresses. On no grant, retries after a timeout and drops the task once retries are exhausted.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT, 1048576, cycles to wait for a grant per attempt; at least 2.
- MAX_RETRY, 3, re-issues allowed after the first attempt; 0 allowed.
- REQUIRE_LINK, 0, 1 = issue only while i_link is high; 0 = ignore i_link.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_push  in  1  enqueue request
- i_task  in  16  task number to enqueue
- o_full  out  1  FIFO full
- o_count  out  clog2(DEPTH)+1  entries held, including the task in flight
- o_overflow  out  1  one-cycle pulse: push rejected
- i_link  in  1  link-up indication from the manager
- o_taskStart  out  1  one-cycle start pulse to the manager
- o_taskNbr  out  16  head task number; stable from ISSUE until the head is popped
- i_grant  in  1  address-grant strobe from the manager
- i_destAddr  in  16  destination address, valid with i_grant
- i_srcAddr  in  16  source address, valid with i_grant
- o_destAddr  out  16  captured destination address
- o_srcAddr  out  16  captured source address
- o_resultValid  out  1  one-cycle pulse: o_destAddr/o_srcAddr updated
- o_drop  out  1  one-cycle pulse: head discarded after retry exhaustion
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM IDLE; timer and retry counter 0. Reset mid-operation aborts the in-flight task and flushes the FIFO.
- FIFO: circular buffer with write/read pointers one bit wider than the index. Full = MSBs differ and indices equal. Empty = pointers equal.
- Push is accepted when not full, or when a pop occurs in the same cycle. A rejected push pulses o_overflow and leaves the FIFO unchanged.
- FSM states:
  - IDLE: go to ISSUE when not empty and (REQUIRE_LINK==0 or i_link). Clear the retry counter on entry from a pop.
  - ISSUE: exactly one cycle; o_taskStart=1; o_taskNbr=head; timer cleared; go to WAIT.
  - WAIT: timer counts up each cycle. On i_grant, go to IDLE. On timer==TIMEOUT-1 without grant: if retry<MAX_RETRY, increment retry and go to GAP; else drop and go to IDLE.
  - GAP: one idle cycle, then ISSUE (the link gate is re-checked; wait in GAP while the gate is closed).
- Grant handling:
  - i_grant is honoured in ISSUE and WAIT. Grant in IDLE or GAP is ignored.
  - On an honoured grant, in the same edge: register i_destAddr/i_srcAddr, pop the head, return to IDLE. o_resultValid pulses the following cycle.
  - Grant wins over timeout when both occur in the same cycle.
- Drop: pop the head; o_drop pulses the following cycle; captured addresses unchanged.
- Latency: with the FSM in IDLE and the FIFO empty, a push in cycle N gives o_taskStart high in cycle N+2. Back-to-back tasks: grant in cycle M, next o_taskStart in cycle M+2.
- REQUIRE_LINK=1 and i_link low: the queue still accepts pushes; nothing issues.
- o_taskNbr holds the head value while the FIFO is not empty, and holds its last value otherwise.

Decomposition:
- Shared package mhp_pkg: FSM state encoding (IDLE, ISSUE, WAIT, GAP) and the task-number constants 16'h0010, 16'h0020, 16'h0030.
- Sub-module task_fifo: parameterised synchronous FIFO with push, pop, full, empty, count and head.
- The dispatcher holds only the FSM, timer, retry counter and capture registers.

Test Plan:
- Single task: push 16'h0020 at cycle 10 -> o_taskStart at cycle 12 with o_taskNbr=0x0020. Grant at cycle 15 with dest=0xFFFF, src=0x0000 -> o_resultValid at 16, o_destAddr=0xFFFF, o_count=0.
- Fill/overflow (DEPTH=8, no grants, REQUIRE_LINK=1, i_link=0): 9 pushes -> o_full after the 8th, o_overflow pulse on the 9th, o_count=8. Push and grant in the same cycle while full -> both accepted, count stays 8.
- Timeout/retry (TIMEOUT=16, MAX_RETRY=2): push 0x0010, never grant -> three o_taskStart pulses spaced 18 cycles apart, then o_drop, o_count=0, addresses unchanged.
- Grant on the timeout cycle (TIMEOUT=16): grant exactly at timer=15 -> o_resultValid, no retry, no o_drop.
- Link gating (REQUIRE_LINK=1): push with i_link=0 for 50 cycles -> no o_taskStart. Raise i_link -> o_taskStart two cycles later.
- Reset mid-WAIT with 3 entries queued -> next cycle: all outputs 0, o_count=0, a subsequent grant is ignored.

Source files
------------

// File: rtl/mhp_pkg.sv
// Shared definitions for the MHP task manager front end: dispatcher states and task-number constants.
`default_nettype none

package mhp_pkg;

   localparam int TASK_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } disp_state_e;

   localparam logic [TASK_W-1:0] TASK_NBR_10 = 16'h0010;
   localparam logic [TASK_W-1:0] TASK_NBR_20 = 16'h0020;
   localparam logic [TASK_W-1:0] TASK_NBR_30 = 16'h0030;

endpackage

`default_nettype wire

// File: rtl/task_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry one extra wrap bit to tell full from empty.
`default_nettype none

module task_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_data,
   output logic                   o_push_ok,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count,
   output logic [WIDTH-1:0]       o_head
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             full;
   logic             empty;
   logic             do_pop;
   logic             push_ok;

   always_comb begin
      full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
      empty   = (wr_ptr_q == rd_ptr_q);
      do_pop  = i_pop && !empty;
      // A pop in the same cycle frees the slot the push needs.
      push_ok = i_push && (!full || do_pop);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q[IDX_W-1:0]] <= i_data;
   end

   assign o_push_ok = push_ok;
   assign o_full    = full;
   assign o_empty   = empty;
   assign o_count   = wr_ptr_q - rd_ptr_q;
   assign o_head    = mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/task_dispatcher.sv
// Queues task numbers and hands them one at a time to the MHP task manager,
// retrying on grant timeout and dropping the task once retries run out.
`default_nettype none

module task_dispatcher
   import mhp_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int TIMEOUT      = 1048576,
   parameter int MAX_RETRY    = 3,
   parameter int REQUIRE_LINK = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [15:0]            i_task,
   output logic                   o_full,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_overflow,
   input  logic                   i_link,
   output logic                   o_taskStart,
   output logic [15:0]            o_taskNbr,
   input  logic                   i_grant,
   input  logic [15:0]            i_destAddr,
   input  logic [15:0]            i_srcAddr,
   output logic [15:0]            o_destAddr,
   output logic [15:0]            o_srcAddr,
   output logic                   o_resultValid,
   output logic                   o_drop,
   output logic                   o_busy
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   disp_state_e       state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [RTY_W-1:0]  retry_q, retry_d;
   logic [15:0]       dest_q, dest_d;
   logic [15:0]       src_q, src_d;
   logic [15:0]       task_nbr_q, task_nbr_d;
   logic              result_valid_q, result_valid_d;
   logic              drop_q, drop_d;
   logic              overflow_q, overflow_d;
   logic              link_q;

   logic              fifo_pop;
   logic              fifo_push_ok;
   logic              fifo_empty;
   logic [15:0]       fifo_head;
   logic              task_start;
   logic              gate_open;

   task_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TASK_W)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_push    (i_push),
      .i_pop     (fifo_pop),
      .i_data    (i_task),
      .o_push_ok (fifo_push_ok),
      .o_full    (o_full),
      .o_empty   (fifo_empty),
      .o_count   (o_count),
      .o_head    (fifo_head)
   );

   // Link comes from the manager's domain logic; it is registered before gating issue.
   assign gate_open = (REQUIRE_LINK == 0) || link_q;

   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      retry_d        = retry_q;
      dest_d         = dest_q;
      src_d          = src_q;
      result_valid_d = 1'b0;
      drop_d         = 1'b0;
      fifo_pop       = 1'b0;
      task_start     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && gate_open) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            task_start = 1'b1;
            timer_d    = '0;
            state_d    = ST_WAIT;
            if (i_grant) begin
               dest_d         = i_destAddr;
               src_d          = i_srcAddr;
               fifo_pop       = 1'b1;
               retry_d        = '0;
               result_valid_d = 1'b1;
               state_d        = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Grant is checked first so it wins over a coincident timeout.
            if (i_grant) begin
               dest_d         = i_destAddr;
               src_d          = i_srcAddr;
               fifo_pop       = 1'b1;
               retry_d        = '0;
               result_valid_d = 1'b1;
               state_d        = ST_IDLE;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               if (int'(retry_q) < MAX_RETRY) begin
                  retry_d = retry_q + RTY_W'(1);
                  state_d = ST_GAP;
               end else begin
                  fifo_pop = 1'b1;
                  drop_d   = 1'b1;
                  retry_d  = '0;
                  state_d  = ST_IDLE;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_GAP: begin
            if (gate_open) state_d = ST_ISSUE;
         end
         default: state_d = ST_IDLE;
      endcase

      task_nbr_d = fifo_empty ? task_nbr_q : fifo_head;
      overflow_d = i_push && !fifo_push_ok;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q        <= ST_IDLE;
         timer_q        <= '0;
         retry_q        <= '0;
         dest_q         <= '0;
         src_q          <= '0;
         task_nbr_q     <= '0;
         result_valid_q <= 1'b0;
         drop_q         <= 1'b0;
         overflow_q     <= 1'b0;
         link_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         retry_q        <= retry_d;
         dest_q         <= dest_d;
         src_q          <= src_d;
         task_nbr_q     <= task_nbr_d;
         result_valid_q <= result_valid_d;
         drop_q         <= drop_d;
         overflow_q     <= overflow_d;
         link_q         <= i_link;
      end
   end

   assign o_overflow    = overflow_q;
   assign o_taskStart   = task_start;
   assign o_taskNbr     = task_nbr_q;
   assign o_destAddr    = dest_q;
   assign o_srcAddr     = src_q;
   assign o_resultValid = result_valid_q;
   assign o_drop        = drop_q;
   assign o_busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_task_dispatcher.sv
// Directed self-checking bench for task_dispatcher (DEPTH=8, TIMEOUT=16, MAX_RETRY=2, link-gated).
`default_nettype none

module tb_task_dispatcher;
   import mhp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        push;
   logic [15:0] tsk;
   logic        full;
   logic [3:0]  count;
   logic        overflow;
   logic        link;
   logic        start;
   logic [15:0] nbr;
   logic        grant;
   logic [15:0] dest_in, src_in;
   logic [15:0] dest_out, src_out;
   logic        rvalid;
   logic        drop;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic seen_a, seen_b;

   always #5 clk = ~clk;

   task_dispatcher #(
      .DEPTH        (8),
      .TIMEOUT      (16),
      .MAX_RETRY    (2),
      .REQUIRE_LINK (1)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_push        (push),
      .i_task        (tsk),
      .o_full        (full),
      .o_count       (count),
      .o_overflow    (overflow),
      .i_link        (link),
      .o_taskStart   (start),
      .o_taskNbr     (nbr),
      .i_grant       (grant),
      .i_destAddr    (dest_in),
      .i_srcAddr     (src_in),
      .o_destAddr    (dest_out),
      .o_srcAddr     (src_out),
      .o_resultValid (rvalid),
      .o_drop        (drop),
      .o_busy        (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; tsk = '0; link = 1'b0;
      grant = 1'b0; dest_in = '0; src_in = '0;
      step(); step();

      // Reset state
      check_eq("rst_start",  start,    0);
      check_eq("rst_count",  count,    0);
      check_eq("rst_full",   full,     0);
      check_eq("rst_ovf",    overflow, 0);
      check_eq("rst_nbr",    nbr,      0);
      check_eq("rst_dest",   dest_out, 0);
      check_eq("rst_rvalid", rvalid,   0);
      check_eq("rst_drop",   drop,     0);
      check_eq("rst_busy",   busy,     0);
      rst = 1'b0;
      link = 1'b1;
      step();

      // Single task: push N, start at N+2, grant at N+5, result at N+6
      push = 1'b1; tsk = TASK_NBR_20;
      step();
      push = 1'b0;
      check_eq("single_cnt1",   count, 1);
      check_eq("single_early",  start, 0);
      step();
      check_eq("single_start",  start, 1);
      check_eq("single_nbr",    nbr,   16'h0020);
      step();
      check_eq("single_pulse1", start, 0);
      check_eq("single_busy",   busy,  1);
      step(); step();
      grant = 1'b1; dest_in = 16'hFFFF; src_in = 16'h0000;
      step();
      grant = 1'b0;
      check_eq("single_rvalid", rvalid,   1);
      check_eq("single_dest",   dest_out, 16'hFFFF);
      check_eq("single_src",    src_out,  16'h0000);
      check_eq("single_cnt0",   count,    0);
      check_eq("single_idle",   busy,     0);
      step();
      check_eq("single_rv_pulse", rvalid, 0);

      // Link gating
      link = 1'b0;
      step();
      push = 1'b1; tsk = TASK_NBR_30;
      step();
      push = 1'b0;
      seen_a = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (start) seen_a = 1'b1;
      end
      check_eq("gate_nostart", seen_a, 0);
      check_eq("gate_cnt",     count,  1);
      check_eq("gate_busy",    busy,   0);
      link = 1'b1;
      step();
      check_eq("gate_wait1", start, 0);
      step();
      check_eq("gate_start", start, 1);
      check_eq("gate_nbr",   nbr,   16'h0030);
      step();
      grant = 1'b1; dest_in = 16'h1234; src_in = 16'h5678;
      step();
      grant = 1'b0;
      check_eq("gate_rvalid", rvalid,   1);
      check_eq("gate_dest",   dest_out, 16'h1234);
      check_eq("gate_src",    src_out,  16'h5678);
      step();

      // Grant on the final timeout cycle (timer == 15)
      push = 1'b1; tsk = TASK_NBR_10;
      step();
      push = 1'b0;
      step();
      check_eq("tog_start", start, 1);
      seen_a = 1'b0; seen_b = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (start) seen_a = 1'b1;
         if (drop)  seen_b = 1'b1;
      end
      check_eq("tog_no_restart", seen_a, 0);
      check_eq("tog_busy",       busy,   1);
      grant = 1'b1; dest_in = 16'hAAAA; src_in = 16'h5555;
      step();
      grant = 1'b0;
      check_eq("tog_rvalid", rvalid,   1);
      check_eq("tog_drop",   drop,     0);
      check_eq("tog_cnt",    count,    0);
      check_eq("tog_dest",   dest_out, 16'hAAAA);
      for (int i = 0; i < 20; i++) begin
         step();
         if (start) seen_a = 1'b1;
         if (drop)  seen_b = 1'b1;
      end
      check_eq("tog_no_retry", seen_a, 0);
      check_eq("tog_no_drop",  seen_b, 0);

      // Timeout / retry / drop: starts 18 cycles apart, drop 17 after the last
      push = 1'b1; tsk = TASK_NBR_10;
      step();
      push = 1'b0;
      step();
      check_eq("rty_start0", start, 1);
      for (int r = 0; r < 2; r++) begin
         seen_a = 1'b0;
         for (int i = 0; i < 17; i++) begin
            step();
            if (start) seen_a = 1'b1;
         end
         check_eq("rty_gap_quiet", seen_a, 0);
         step();
         check_eq("rty_restart", start, 1);
      end
      seen_a = 1'b0; seen_b = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (start) seen_a = 1'b1;
         if (drop)  seen_b = 1'b1;
      end
      check_eq("rty_last_quiet", seen_a | seen_b, 0);
      step();
      check_eq("rty_drop",   drop,     1);
      check_eq("rty_cnt",    count,    0);
      check_eq("rty_idle",   busy,     0);
      check_eq("rty_rvalid", rvalid,   0);
      check_eq("rty_dest",   dest_out, 16'hAAAA);
      check_eq("rty_src",    src_out,  16'h5555);
      step();
      check_eq("rty_drop_pulse", drop,  0);
      check_eq("rty_no_more",    start, 0);

      // Fill and overflow with the link down
      link = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         push = 1'b1; tsk = 16'h0100 + 16'(i);
         step();
         if (i == 6) check_eq("fill_not_full7", full, 0);
      end
      check_eq("fill_full8", full,  1);
      check_eq("fill_cnt8",  count, 8);
      check_eq("fill_ovf0",  overflow, 0);
      tsk = 16'h0108;
      step();
      push = 1'b0;
      check_eq("fill_ovf",     overflow, 1);
      check_eq("fill_cnt_ovf", count,    8);
      step();
      check_eq("fill_ovf_pulse", overflow, 0);
      check_eq("fill_head",      nbr,      16'h0100);
      link = 1'b1;
      step(); step();
      check_eq("fill_start", start, 1);
      step();
      push = 1'b1; tsk = 16'h01FF; link = 1'b0;
      grant = 1'b1; dest_in = 16'h0BEE; src_in = 16'h0CAF;
      step();
      push = 1'b0; grant = 1'b0;
      check_eq("pg_cnt",    count,    8);
      check_eq("pg_full",   full,     1);
      check_eq("pg_ovf",    overflow, 0);
      check_eq("pg_rvalid", rvalid,   1);
      check_eq("pg_dest",   dest_out, 16'h0BEE);
      step();
      check_eq("pg_next_head", nbr,  16'h0101);
      check_eq("pg_idle",      busy, 0);

      // Reset mid-WAIT with three entries queued
      rst = 1'b1;
      step();
      rst = 1'b0; link = 1'b1;
      push = 1'b1; tsk = TASK_NBR_10; step();
      tsk = TASK_NBR_20; step();
      tsk = TASK_NBR_30; step();
      push = 1'b0;
      check_eq("mid_busy", busy,  1);
      check_eq("mid_cnt",  count, 3);
      check_eq("mid_start_gone", start, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mr_start", start,    0);
      check_eq("mr_cnt",   count,    0);
      check_eq("mr_busy",  busy,     0);
      check_eq("mr_full",  full,     0);
      check_eq("mr_nbr",   nbr,      0);
      check_eq("mr_dest",  dest_out, 0);
      check_eq("mr_src",   src_out,  0);
      check_eq("mr_drop",  drop,     0);
      grant = 1'b1; dest_in = 16'h7777; src_in = 16'h8888;
      step();
      grant = 1'b0;
      check_eq("mr_grant_ignored", rvalid,   0);
      check_eq("mr_dest_kept",     dest_out, 0);
      check_eq("mr_still_idle",    busy,     0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
